// File: rtl/register_memory_interface.sv
// register_memory_interface: register file + data memory moved by a 2-bit opcode, registered data_out.
// Optional RMI_ECHO_EN: data_out also shows the value moved by every opcode.
module register_memory_interface #(
  parameter int DATA_W = 4,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] reg_adrs,
  input  logic [MEM_AW-1:0] mem_adrs,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        opcode,
  output logic [DATA_W-1:0] data_out
);
  logic [DATA_W-1:0] regs [2**REG_AW];
  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [DATA_W-1:0] mem_rd, reg_rd, mem_wd;
  logic              mem_we, reg_we, out_we;
  always_comb begin
    mem_rd = mem[mem_adrs];
    reg_rd = regs[reg_adrs];
    mem_wd = opcode[0] ? reg_rd : data_in;
    mem_we = ~opcode[1];
    reg_we = opcode == 2'd2;
`ifdef RMI_ECHO_EN
    out_we = 1'b1;
`else
    out_we = opcode == 2'd3;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= '0;
      data_out <= '0;
    end else begin
      if (mem_we) mem[mem_adrs] <= mem_wd;
      if (reg_we) regs[reg_adrs] <= mem_rd;
      // opcodes 2 and 3 both move a memory word; 0 and 1 move mem_wd
      if (out_we) data_out <= opcode[1] ? mem_rd : mem_wd;
    end
  end
endmodule

// File: tb/tb_register_memory_interface.sv
// tb_register_memory_interface: directed plan plus random opcodes checked against an array model.
module tb_register_memory_interface;
  logic       clk = 0, rst = 1;
  logic [3:0] reg_adrs = 0, mem_adrs = 0, data_in = 0, data_out;
  logic [1:0] opcode = 0;
  logic [3:0] m_reg [16];
  logic [3:0] m_mem [16];
  logic [3:0] m_out;
  int errors = 0, checks = 0;
  register_memory_interface dut (
    .clk(clk), .rst(rst), .reg_adrs(reg_adrs), .mem_adrs(mem_adrs),
    .data_in(data_in), .opcode(opcode), .data_out(data_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: data_out=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_reg[i] = 0;
      m_mem[i] = 0;
    end
    m_out = 0;
  endtask
  task automatic do_op(input string tag, input logic [1:0] opc, input logic [3:0] ra, input logic [3:0] ma, input logic [3:0] di);
    logic [3:0] moved;
    opcode = opc; reg_adrs = ra; mem_adrs = ma; data_in = di;
    @(posedge clk);
    moved = opc == 0 ? di : opc == 1 ? m_reg[ra] : m_mem[ma];
    if (opc == 0 || opc == 1) m_mem[ma] = moved;
    if (opc == 2) m_reg[ra] = moved;
`ifdef RMI_ECHO_EN
    m_out = moved;
`else
    if (opc == 3) m_out = moved;
`endif
    @(negedge clk);
    check(tag, data_out, m_out);
  endtask
  initial begin
    model_clear();
    #1 check("reset_async", data_out, 4'd0);
    repeat (2) @(negedge clk);
    check("reset_hold", data_out, 4'd0);
    rst = 0;
    for (int i = 0; i < 3; i++) do_op("p1_load_mem", 2'd0, 4'd0, 4'(i), 4'(i));
    do_op("p2_load_reg", 2'd2, 4'd0, 4'd1, 4'd4);
    do_op("p3_store_reg_a", 2'd1, 4'd0, 4'd3, 4'd0);
    do_op("p3_store_reg_b", 2'd1, 4'd0, 4'd4, 4'd0);
    do_op("p4_out_2", 2'd3, 4'd0, 4'd2, 4'd0);
    check("p4_const_2", data_out, 4'd2);
    do_op("p4_out_3", 2'd3, 4'd0, 4'd3, 4'd0);
    check("p4_const_1", data_out, 4'd1);
    do_op("p4_out_4", 2'd3, 4'd0, 4'd4, 4'd0);
    check("p4_const_1b", data_out, 4'd1);
    do_op("p4_out_15", 2'd3, 4'd0, 4'd15, 4'd0);
    check("p4_const_0", data_out, 4'd0);
    do_op("p5_load_9", 2'd0, 4'd0, 4'd5, 4'd9);
    do_op("p5_out_5", 2'd3, 4'd0, 4'd5, 4'd0);
    check("p5_const_9", data_out, 4'd9);
    do_op("p5_hold", 2'd0, 4'd0, 4'd6, 4'd7);
    #2 rst = 1;
    #1 check("p6_async_rst", data_out, 4'd0);
    model_clear();
    @(negedge clk);
    check("p6_rst_hold", data_out, 4'd0);
    rst = 0;
    do_op("p6_mem_cleared", 2'd3, 4'd0, 4'd2, 4'd0);
    check("p6_const_0", data_out, 4'd0);
    for (int n = 0; n < 400; n++)
      do_op("rand_op", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 16; i++) do_op("dump_mem", 2'd3, 4'd0, 4'(i), 4'd0);
    for (int i = 0; i < 16; i++) begin
      do_op("copy_reg", 2'd1, 4'(i), 4'd0, 4'd0);
      do_op("dump_reg", 2'd3, 4'd0, 4'd0, 4'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
